// File: rtl/load_store_unit.sv
// Load/store unit between the RV32I memory stage and a word-only data memory.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   merged_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic                    illegal;
    logic [4:0]              lane_shift;
    logic [DATA_WIDTH-1:0]   shifted_rd;
    logic [7:0]              sel_byte;
    logic [15:0]             sel_half;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   merge_val;

    // Request legality is judged on the live inputs, since it is only used at accept.
    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000: illegal = 1'b0;
            3'b001: illegal = addr[0];
            3'b010: illegal = (addr[1:0] != 2'b00);
            3'b100: illegal = we;
            3'b101: illegal = we | addr[0];
            default: illegal = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS)) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        shifted_rd = mem_rd >> lane_shift;
        sel_byte   = shifted_rd[7:0];
        sel_half   = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        case (funct3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {24'h000000, sel_byte};
            3'b101:  load_val = {16'h0000, sel_half};
            default: load_val = mem_rd;
        endcase

        case (funct3_q)
            3'b000: merge_val = (mem_rd & ~(32'h0000_00FF << lane_shift))
                              | ({24'h000000, wdata_q[7:0]} << lane_shift);
            3'b001: merge_val = addr_q[1] ? {wdata_q[15:0], mem_rd[15:0]}
                                          : {mem_rd[31:16], wdata_q[15:0]};
            default: merge_val = mem_rd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                we_q     <= we;
                funct3_q <= funct3;
                addr_q   <= addr;
                wdata_q  <= wdata;
                err_q    <= illegal;
            end
            if (state == READ) begin
                if (we_q) begin
                    merged_q <= merge_val;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_nxt = RESP;
                    end else if (we && funct3 == 3'b010) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:    state_nxt = we_q ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port is driven only while an access is in flight and is zero otherwise.
    always_comb begin
        ready    = (state == IDLE);
        done     = (state == RESP);
        err      = (state == RESP) && err_q;
        rdata    = rdata_q;
        mem_we   = (state == WRITE);
        mem_addr = 32'h0;
        mem_wd   = '0;
        if (state == READ || state == WRITE) begin
            mem_addr = {addr_q[31:2], 2'b00};
        end
        if (state == WRITE) begin
            mem_wd = (funct3_q == 3'b010) ? wdata_q : merged_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic
// compared against an arithmetic reference model of memory and load results.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    int n_checks;
    int n_fails;

    load_store_unit #(.DATA_WIDTH(32), .MEM_WORDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory: combinational read, synchronous word write.
    assign mem_rd = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wd;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic model_illegal(input logic w, input logic [2:0] f3,
                                           input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (w && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
        if ((a / 4) >= 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        int sh;
        w  = ref_mem[int'(a / 4)];
        sh = int'(a % 4) * 8;
        case (f3)
            3'd0: begin v = (w >> sh) & 32'd255;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = (w >> sh) & 32'd65535; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = (w >> sh) & 32'd255;
            3'd5: v = (w >> sh) & 32'd65535;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] mask;
        int sh;
        w  = ref_mem[int'(a / 4)];
        sh = int'(a % 4) * 8;
        case (f3)
            3'd0:    mask = 32'd255;
            3'd1:    mask = 32'd65535;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (w & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    // Drives one request from a negedge and follows it to done; leaves the bench at the done negedge.
    task automatic apply_stimulus(input logic op_we, input logic [2:0] op_f3,
                                  input logic [31:0] op_addr, input logic [31:0] op_wdata,
                                  input logic hold, input int exp_waits);
        int          waits;
        int          cycles;
        int          pulses;
        int          exp_lat;
        int          exp_pulses;
        logic [31:0] pulse_addr;
        logic        ready_low;
        logic        exp_err;
        logic [31:0] exp_word;
        int          idx;

        req    = 1'b1;
        we     = op_we;
        funct3 = op_f3;
        addr   = op_addr;
        wdata  = op_wdata;

        waits = 0;
        while (!ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check_output("ready_for_accept", {31'd0, ready}, 32'd1);
        if (exp_waits >= 0) check_output("accept_wait", waits, exp_waits);

        exp_err    = model_illegal(op_we, op_f3, op_addr);
        idx        = int'(op_addr / 4);
        exp_pulses = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!op_we) begin
            exp_lat   = 2;
            ref_rdata = model_load(op_f3, op_addr);
        end else begin
            exp_lat      = (op_f3 == 3'd2) ? 2 : 3;
            exp_pulses   = 1;
            ref_mem[idx] = model_store(op_f3, op_addr, op_wdata);
        end

        cycles     = 0;
        pulses     = 0;
        pulse_addr = 32'h0;
        ready_low  = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                req   = hold;
                addr  = $urandom;
                wdata = $urandom;
            end
            if (ready) ready_low = 1'b0;
            if (mem_we) begin
                pulses++;
                pulse_addr = mem_addr;
            end
        end while (!done && cycles < 10);

        check_output("done_seen", {31'd0, done}, 32'd1);
        check_output("latency", cycles, exp_lat);
        check_output("err", {31'd0, err}, {31'd0, exp_err});
        check_output("rdata", rdata, ref_rdata);
        check_output("mem_we_pulses", pulses, exp_pulses);
        check_output("ready_low_busy", {31'd0, ready_low}, 32'd1);
        if (exp_pulses == 1) begin
            check_output("pulse_addr", pulse_addr, op_addr & 32'hFFFF_FFFC);
        end
        if (idx < 64) begin
            check_output("mem_word", mem[idx], ref_mem[idx]);
        end
        if (!hold) req = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        ref_rdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n  = 1'b0;
        req    = 1'b0;
        we     = 1'b0;
        funct3 = 3'b000;
        addr   = 32'h0;
        wdata  = 32'h0;

        repeat (2) @(negedge clk);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'h0);
        check_output("rst_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_ready", {31'd0, ready}, 32'd1);

        // Reset during the WRITE cycle of an SW must abort before the write edge.
        req    = 1'b1;
        we     = 1'b1;
        funct3 = 3'b010;
        addr   = 32'h30;
        wdata  = 32'hCAFE_F00D;
        @(negedge clk);
        req = 1'b0;
        check_output("midop_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midop_we_drop", {31'd0, mem_we}, 32'd0);
        check_output("midop_addr_drop", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("midop_ready", {31'd0, ready}, 32'd1);
        check_output("midop_word", mem[12], 32'h0);

        $display("[TB] directed word/byte/half cases");
        apply_stimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 0);
        apply_stimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, -1);
        check_output("lw_value", rdata, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 3'b000, 32'h12, 32'h55, 1'b0, -1);
        check_output("sb_word", mem[4], 32'hDE55_BEEF);
        apply_stimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, -1);
        check_output("lb_value", rdata, 32'hFFFF_FFDE);
        apply_stimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, -1);
        check_output("lbu_value", rdata, 32'h0000_00DE);
        apply_stimulus(1'b1, 3'b001, 32'h22, 32'h8001, 1'b0, -1);
        check_output("sh_word", mem[8], 32'h8001_0000);
        apply_stimulus(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, -1);
        check_output("lh_value", rdata, 32'hFFFF_8001);
        apply_stimulus(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, -1);
        check_output("lhu_value", rdata, 32'h0000_8001);

        $display("[TB] directed error cases");
        apply_stimulus(1'b0, 3'b010, 32'h06, 32'h0, 1'b0, -1);
        check_output("lw_misaligned_rdata", rdata, 32'h0000_8001);
        apply_stimulus(1'b1, 3'b001, 32'h03, 32'h1234, 1'b0, -1);
        apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, -1);
        apply_stimulus(1'b0, 3'b011, 32'h00, 32'h0, 1'b0, -1);

        $display("[TB] back-to-back with req held");
        @(negedge clk);
        apply_stimulus(1'b1, 3'b010, 32'h00, 32'h1357_9BDF, 1'b1, 0);
        apply_stimulus(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 1);
        check_output("b2b_lw_value", rdata, 32'h1357_9BDF);

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            r_we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       r_f3 = 3'($urandom_range(0, 7));
                1, 2:    r_f3 = 3'd0;
                3, 4:    r_f3 = 3'd1;
                5, 6:    r_f3 = 3'd2;
                7:       r_f3 = 3'd4;
                default: r_f3 = 3'd5;
            endcase
            case ($urandom_range(0, 9))
                0:       r_addr = $urandom;
                1:       r_addr = 32'($urandom_range(256, 511));
                default: r_addr = 32'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            apply_stimulus(r_we, r_f3, r_addr, $urandom, 1'b0, -1);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            check_output("final_mem", mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I core's memory stage and the word-only data memory; that memory has an asynchronous read and a synchronous word write.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned accesses: sign/zero extension on loads, read-modify-write on sub-word stores.
- Flags misaligned, out-of-range and illegal requests.
- Req/ready/done handshake; the core stalls while ready is low.

Parameters:
- DATA_WIDTH, 32, data word width (only 32 supported).
- MEM_WORDS, 64, number of words in the attached memory; used for the range check.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  core request valid
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- ready  out  1  block idle; request accepted when req && ready
- done  out  1  one-cycle pulse: operation complete
- rdata  out  32  extended load result; valid when done, held until next done
- err  out  1  valid with done: request rejected, memory untouched
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned byte address to memory
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; done=0, err=0, rdata=0, mem_we=0, mem_addr=0, mem_wd=0; ready=1 after release.
  - Asserting reset mid-operation aborts it; mem_we drops immediately and no partial write occurs.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - ready=1.
  - On req, register we, funct3, addr, wdata.
  - Next state: RESP with err=1 if illegal; else READ for loads, SB and SH; else WRITE for SW.
- Illegal request, any one of:
  - funct3 is 011, 110 or 111
  - funct3 is 100 or 101 with we=1
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - addr[31:2] >= MEM_WORDS
- READ:
  - mem_addr={addr_q[31:2],2'b00}.
  - Load: select byte/half by addr_q[1:0]/addr_q[1]. Sign-extend for B/H, zero-extend for BU/HU; W passes through. Register the result into rdata; next state RESP.
  - SB/SH: register the merge of mem_rd with wdata_q[7:0]/[15:0] at the addressed lane, other lanes preserved; next state WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle.
  - mem_addr as in READ.
  - mem_wd = wdata_q for SW, the merged word for SB/SH.
  - Next state RESP.
- RESP:
  - done=1 and err as determined; next state IDLE.
  - err=1 leaves rdata unchanged. Stores do not change rdata.
- Outside READ/WRITE: mem_we=0, mem_addr=0.
- Latency (accept edge to done cycle):
  - illegal 1
  - load 2
  - SW 2
  - SB/SH 3
- Throughput: ready is low from the cycle after accept until return to IDLE. A back-to-back req held high is accepted on the first IDLE cycle.
- req while ready=0 is ignored; the core must hold req and its fields until accepted.
- Inputs sampled only at accept. Changes to addr/wdata after accept have no effect.

Test Plan:
- Reset mid-op: reset asserted during the WRITE state of SW -> mem_we=0 immediately, word unchanged, ready=1 after release.
- Word store/load: SW addr=0x10, wdata=0xDEADBEEF -> mem_we pulse 1 cycle at mem_addr=0x10, done 2 cycles after accept. Then LW 0x10 -> rdata=0xDEADBEEF, err=0.
- Byte RMW: word 0x10 holds 0xDEADBEEF; SB addr=0x12, wdata=0x55 -> done 3 cycles after accept, memory 0xDE55BEEF. LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
- Halfword: SH addr=0x22, wdata=0x8001 into word 0x00000000 -> 0x80010000. LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- Errors:
  - LW addr=0x06 -> done 1 cycle after accept, err=1, no mem_we, rdata unchanged.
  - SH addr=0x03 -> err=1.
  - LW addr=0x100 with MEM_WORDS=64 -> err=1.
  - funct3=011 -> err=1.
- Back-to-back: req held high over SW 0x00 then LW 0x00 -> second accept on the cycle after the first done. LW returns the stored value; ready low throughout both operations except IDLE cycles.
